delayslot_tracker: RTL and testbench
====================================

DELAYSLOT_TRACKER -- requirements
Module: delayslot_tracker

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter STAGES, default 3, number of tracking stages from issue to commit (min 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 issue_valid  input  1  instruction leaves issue stage this cycle.
REQ-006 issue_pc  input  ADDR_W  PC of issuing instruction.
REQ-007 issue_is_br  input  1  issuing instruction is a branch/jump with a delay slot.
REQ-008 stall  input  STAGES  per-stage hold; bit k holds stage k and all younger stages.
REQ-009 flush  input  STAGES  per-stage kill; bit k clears stage k and all younger stages, plus the armed state.
REQ-010 annul_ds  input  1  branch-likely not taken; cancel the pending delay slot (DS_LIKELY_EN only).
REQ-011 armed  output  1  a branch has issued and its delay slot has not yet issued.
REQ-012 cm_valid  output  1  valid instruction in last stage.
REQ-013 cm_bd  output  1  last-stage instruction is in a delay slot.
REQ-014 cm_br_addr  output  ADDR_W  PC of the owning branch when cm_bd=1, else 0.
REQ-015 cm_epc  output  ADDR_W  cm_bd ? cm_br_addr : last-stage PC.

Function
REQ-016 Armed register: set, with armed_addr=issue_pc, when issue_valid && issue_is_br && !stall[0] && no flush.
REQ-017 Issue into stage 0 when issue_valid && !stall[0]: entry {valid=1, bd=armed, br_addr=armed?armed_addr:0, pc=issue_pc}.
REQ-018 Armed clears when its delay-slot instruction issues, unless that instruction is itself a branch; then armed stays 1, armed_addr=new issue_pc, entry bd=1 with old armed_addr.
REQ-019 While stall[0]=1, armed and armed_addr hold regardless of issue_valid.
REQ-020 Stage k+1 loads stage k when !stall[k+1]; if stall[k] && !stall[k+1], stage k+1 loads a bubble (valid=0).
REQ-021 Stage 0 loads a bubble when !stall[0] && !issue_valid.
REQ-022 Any flush bit set: armed cleared same edge; flushed stages become bubbles; flush overrides stall and issue.
REQ-023 Latency: an issued instruction reaches cm_* outputs STAGES cycles after issue when no stalls.
REQ-024 cm_* outputs are registered from the last stage; cm_bd, cm_br_addr, cm_epc are 0 when cm_valid=0.
REQ-025 Branch as last issue before a flush loses its delay-slot association; no entry with bd=1 may follow a flush until a new branch issues.

Reset
REQ-026 On reset: armed=0, armed_addr=0, all stages bubbles, all outputs 0.
REQ-027 Reset mid-operation discards pending delay-slot state; reset overrides stall, flush and issue.

Configuration
REQ-028 Macro DS_LIKELY_EN: when defined, annul_ds with armed=1 causes the next issued instruction to enter stage 0 as a bubble and clears armed; annul_ds with armed=0 has no effect.
REQ-029 When DS_LIKELY_EN is undefined, annul_ds is ignored and no annul logic is synthesised.

Structure
REQ-030 Package ds_pkg holds typedef ds_entry_t {valid, bd, pc, br_addr} and default ADDR_W/STAGES constants.
REQ-031 One sub-module ds_stage_reg implements a single stage register with stall, flush and bubble insertion, instantiated STAGES times via generate.

Verification
REQ-032 Reset, then branch at 0x00400000 followed by 0x00400004, no stalls -> after 3 cycles cm_bd=0 cm_epc=0x00400000; next cycle cm_bd=1 cm_br_addr=0x00400000 cm_epc=0x00400000.
REQ-033 Branch at 0x100 issues, stall[0]=1 for 4 cycles, then 0x104 issues -> armed=1 throughout stall; 0x104 commits with cm_bd=1 cm_br_addr=0x100.
REQ-034 Branch at 0x200 issues, flush[0]=1 next cycle, then 0x300 issues -> armed=0 after flush; 0x300 commits with cm_bd=0 cm_epc=0x300.
REQ-035 Branch at 0x400, branch at 0x404, 0x408 issue back-to-back -> 0x404 commits cm_bd=1 br_addr=0x400; 0x408 commits cm_bd=1 br_addr=0x404.
REQ-036 DS_LIKELY_EN defined: branch at 0x500, annul_ds=1, 0x504 issues -> 0x504 never commits (cm_valid=0 in its slot), armed=0; undefined: 0x504 commits with cm_bd=1.
REQ-037 Reset asserted while armed=1 and all stages valid -> next cycle all outputs 0, armed=0.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared types and defaults for the delay-slot tracker pipeline.
// Entry fields are sized to DS_PC_W_MAX so any ADDR_W up to that width fits.
package ds_pkg;

  localparam int DS_ADDR_W   = 32;
  localparam int DS_STAGES   = 3;
  localparam int DS_PC_W_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic                   bd;
    logic [DS_PC_W_MAX-1:0] pc;
    logic [DS_PC_W_MAX-1:0] br_addr;
  } ds_entry_t;

  function automatic ds_entry_t ds_bubble();
    ds_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/ds_stage_reg.sv
// One tracking stage: holds on stall, clears on kill, and takes a bubble
// when its upstream source is stalled or being killed.
module ds_stage_reg
  import ds_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      kill,
  input  logic      hold,
  input  logic      bubble,
  input  ds_entry_t d,
  output ds_entry_t q
);

  // Stage register; kill outranks hold, hold outranks bubble/load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= ds_bubble();
    end else if (kill) begin
      q <= ds_bubble();
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= ds_bubble();
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/delayslot_tracker.sv
// Tracks branch delay-slot ownership from issue to commit across STAGES stages.
// Optional branch-likely annul support is enabled by defining DS_LIKELY_EN.
module delayslot_tracker
  import ds_pkg::*;
#(
  parameter int ADDR_W = DS_ADDR_W,
  parameter int STAGES = DS_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_pc,
  input  logic              issue_is_br,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  input  logic              annul_ds,
  output logic              armed,
  output logic              cm_valid,
  output logic              cm_bd,
  output logic [ADDR_W-1:0] cm_br_addr,
  output logic [ADDR_W-1:0] cm_epc
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [ADDR_W-1:0] armed_addr;
  logic              armed_n;
  logic [ADDR_W-1:0] armed_addr_n;
  logic              squash;
  ds_entry_t         stg       [STAGES];
  ds_entry_t         stage_d   [STAGES];
  logic [STAGES-1:0] stage_bub;
  ds_entry_t         last;
  logic              commit;
  logic              unused_hi;

  // A stall or flush on an older stage also affects every younger stage.
  always_comb begin
    hold = '0;
    kill = '0;
    hold[STAGES-1] = stall[STAGES-1];
    kill[STAGES-1] = flush[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      hold[k] = stall[k] | hold[k+1];
      kill[k] = flush[k] | kill[k+1];
    end
  end

`ifdef DS_LIKELY_EN
  logic annul_pend;

  // An annul seen with no issue this cycle is remembered for the next issue.
  assign squash = annul_pend | (annul_ds & armed);

  // Pending-annul flag: cleared by flush or by consuming an issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      annul_pend <= 1'b0;
    end else if (kill[0]) begin
      annul_pend <= 1'b0;
    end else if (!hold[0] && issue_valid) begin
      annul_pend <= 1'b0;
    end else if (annul_ds && armed) begin
      annul_pend <= 1'b1;
    end else begin
      annul_pend <= annul_pend;
    end
  end
`else
  logic unused_annul;

  assign squash       = 1'b0;
  assign unused_annul = annul_ds;
`endif

  // Next armed state; a branch in a delay slot re-arms with its own PC.
  always_comb begin
    armed_n      = armed;
    armed_addr_n = armed_addr;
    if (kill[0]) begin
      armed_n = 1'b0;
    end else if (!hold[0]) begin
      if (issue_valid) begin
        if (squash) begin
          armed_n = 1'b0;
        end else if (issue_is_br) begin
          armed_n      = 1'b1;
          armed_addr_n = issue_pc;
        end else begin
          armed_n = 1'b0;
        end
      end else if (squash) begin
        armed_n = 1'b0;
      end else begin
        armed_n = armed;
      end
    end else begin
      armed_n = armed;
    end
  end

  // Armed register.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b0;
      armed_addr <= '0;
    end else begin
      armed      <= armed_n;
      armed_addr <= armed_addr_n;
    end
  end

  // Stage inputs: stage 0 is fed by issue, every other stage by its predecessor.
  always_comb begin
    stage_d[0]          = ds_bubble();
    stage_d[0].valid    = 1'b1;
    stage_d[0].bd       = armed;
    stage_d[0].pc[ADDR_W-1:0] = issue_pc;
    if (armed) begin
      stage_d[0].br_addr[ADDR_W-1:0] = armed_addr;
    end else begin
      stage_d[0].br_addr = '0;
    end
    stage_bub    = '0;
    stage_bub[0] = ~issue_valid | squash;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k]   = stg[k-1];
      stage_bub[k] = hold[k-1] | kill[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ds_stage_reg u_stage (
      .clk    (clk),
      .reset  (reset),
      .kill   (kill[k]),
      .hold   (hold[k]),
      .bubble (stage_bub[k]),
      .d      (stage_d[k]),
      .q      (stg[k])
    );
  end

  // A held or killed last-stage entry does not commit, so nothing commits twice.
  assign last      = stg[STAGES-1];
  assign commit    = last.valid & ~hold[STAGES-1] & ~kill[STAGES-1];
  assign unused_hi = ^{last.pc, last.br_addr};

  // Commit outputs, forced to zero when no instruction commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cm_valid   <= 1'b0;
      cm_bd      <= 1'b0;
      cm_br_addr <= '0;
      cm_epc     <= '0;
    end else begin
      cm_valid   <= commit;
      cm_bd      <= commit & last.bd;
      cm_br_addr <= (commit && last.bd) ? last.br_addr[ADDR_W-1:0] : '0;
      if (!commit) begin
        cm_epc <= '0;
      end else if (last.bd) begin
        cm_epc <= last.br_addr[ADDR_W-1:0];
      end else begin
        cm_epc <= last.pc[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_delayslot_tracker.sv
// Scoreboard bench for delayslot_tracker; expectations follow DS_LIKELY_EN.
module tb_delayslot_tracker;

  localparam int AW = 32;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_pc;
  logic          issue_is_br;
  logic [ST-1:0] stall;
  logic [ST-1:0] flush;
  logic          annul_ds;
  logic          armed;
  logic          cm_valid;
  logic          cm_bd;
  logic [AW-1:0] cm_br_addr;
  logic [AW-1:0] cm_epc;

  typedef struct packed {
    logic          bd;
    logic [AW-1:0] br;
    logic [AW-1:0] epc;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  logic          m_armed;
  logic [AW-1:0] m_addr;

  delayslot_tracker #(.ADDR_W(AW), .STAGES(ST)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_pc    (issue_pc),
    .issue_is_br (issue_is_br),
    .stall       (stall),
    .flush       (flush),
    .annul_ds    (annul_ds),
    .armed       (armed),
    .cm_valid    (cm_valid),
    .cm_bd       (cm_bd),
    .cm_br_addr  (cm_br_addr),
    .cm_epc      (cm_epc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Commit monitor: every commit must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (cm_valid) begin
        check_eq("commit_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("cm_bd", 64'(cm_bd), 64'(e.bd));
          check_eq("cm_br_addr", 64'(cm_br_addr), 64'(e.br));
          check_eq("cm_epc", 64'(cm_epc), 64'(e.epc));
        end
      end else begin
        check_eq("idle_zero", 64'(|{cm_bd, cm_br_addr, cm_epc}), 64'd0);
      end
    end
  end

  task automatic issue(input logic [AW-1:0] pc, input logic br, input logic commits);
    exp_t e;
    issue_valid = 1'b1;
    issue_pc    = pc;
    issue_is_br = br;
    if (commits) begin
      e.bd  = m_armed;
      e.br  = m_armed ? m_addr : '0;
      e.epc = m_armed ? m_addr : pc;
      sb.push_back(e);
    end
    m_armed = br;
    if (br) m_addr = pc;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_is_br = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_pc = '0; issue_is_br = 1'b0;
    stall = '0; flush = '0; annul_ds = 1'b0;
    m_armed = 1'b0; m_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_armed", 64'(armed), 64'd0);
    check_eq("rst_outputs", 64'(|{cm_valid, cm_bd, cm_br_addr, cm_epc}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Branch + delay slot, checking commit latency.
    issue(32'h0040_0000, 1'b1, 1'b1);
    check_eq("armed_after_br", 64'(armed), 64'd1);
    issue(32'h0040_0004, 1'b0, 1'b1);
    check_eq("armed_after_ds", 64'(armed), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("lat_br_valid", 64'(cm_valid), 64'd1);
    check_eq("lat_br_bd", 64'(cm_bd), 64'd0);
    check_eq("lat_br_epc", 64'(cm_epc), 64'h0040_0000);
    @(posedge clk); #1;
    check_eq("lat_ds_bd", 64'(cm_bd), 64'd1);
    check_eq("lat_ds_br", 64'(cm_br_addr), 64'h0040_0000);
    check_eq("lat_ds_epc", 64'(cm_epc), 64'h0040_0000);
    drain();

    // Branch, then stall[0] for four cycles with a blocked issue attempt.
    issue(32'h100, 1'b1, 1'b1);
    stall = 3'b001; issue_valid = 1'b1; issue_pc = 32'hdead;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("armed_in_stall", 64'(armed), 64'd1);
    end
    stall = '0;
    issue(32'h104, 1'b0, 1'b1);
    drain();

    // Branch killed by a flush loses its delay slot.
    issue(32'h200, 1'b1, 1'b0);
    flush = 3'b001;
    @(posedge clk); #1;
    flush = '0; m_armed = 1'b0;
    check_eq("armed_after_flush", 64'(armed), 64'd0);
    issue(32'h300, 1'b0, 1'b1);
    drain();

    // Branch in a delay slot, with a last-stage stall while in flight.
    issue(32'h400, 1'b1, 1'b1);
    issue(32'h404, 1'b1, 1'b1);
    issue(32'h408, 1'b0, 1'b1);
    stall = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    stall = '0;
    drain();

    // Annul of the pending delay slot.
    issue(32'h500, 1'b1, 1'b1);
    annul_ds = 1'b1;
    @(posedge clk); #1;
    annul_ds = 1'b0;
`ifdef DS_LIKELY_EN
    m_armed = 1'b0;
    check_eq("annul_armed", 64'(armed), 64'(m_armed));
    issue(32'h504, 1'b0, 1'b0);
`else
    check_eq("annul_armed", 64'(armed), 64'(m_armed));
    issue(32'h504, 1'b0, 1'b1);
`endif
    check_eq("armed_after_annul", 64'(armed), 64'd0);
    issue(32'h508, 1'b0, 1'b1);
    drain();

    // Reset with a full pipeline and armed=1.
    issue(32'h600, 1'b1, 1'b0);
    issue(32'h604, 1'b1, 1'b0);
    issue(32'h608, 1'b1, 1'b0);
    check_eq("armed_pre_reset", 64'(armed), 64'd1);
    reset = 1'b1; issue_valid = 1'b1; issue_pc = 32'h60c; issue_is_br = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_armed", 64'(armed), 64'd0);
    check_eq("mid_rst_outputs", 64'(|{cm_valid, cm_bd, cm_br_addr, cm_epc}), 64'd0);
    reset = 1'b0; issue_valid = 1'b0; issue_is_br = 1'b0; m_armed = 1'b0;
    @(posedge clk); #1;
    issue(32'h700, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
